// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled, majority-voted serial-to-parallel
// conversion with start-glitch rejection, optional parity and stop checking.
module uart_rx_deserializer #(
    parameter int Width     = 8,
    parameter int PrescaleW = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX_IN,
    input  logic [PrescaleW-1:0] Prescale,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    output logic [Width-1:0]     P_DATA,
    output logic                 Data_Valid,
    output logic                 Parity_Error,
    output logic                 Stop_Error
);
    localparam int BitW = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [PrescaleW-1:0] MaxEdge = PrescaleW'(31);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_mismatch(input logic [Width-1:0] data,
                                             input logic par_bit, input logic odd);
        return par_bit ^ (^data) ^ odd;
    endfunction

    state_e                state_q, state_d;
    logic                  sync1_q, sync2_q, rx_s;
    logic [PrescaleW-1:0]  edge_cnt_q, edge_cnt_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  s0_q, s0_d, s1_q, s1_d;
    logic [Width-1:0]      shift_q, shift_d;
    logic [PrescaleW-1:0]  pres_q, pres_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  par_err_q, par_err_d, stop_err_q, stop_err_d;
    logic [Width-1:0]      p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  stop_error_q, stop_error_d;
    logic [PrescaleW-1:0]  half_s;
    logic                  wrap_s, sample_s, vote_s, stop_bad_s;

    assign rx_s         = sync2_q;
    assign P_DATA       = p_data_q;
    assign Data_Valid   = data_valid_q;
    assign Parity_Error = parity_error_q;
    assign Stop_Error   = stop_error_q;

    // Bit-period timing: wrap also at 31 so an illegal prescale cannot stretch a bit past 32 cycles.
    always_comb begin
        half_s   = pres_q >> 1;
        wrap_s   = (edge_cnt_q == pres_q - PrescaleW'(1)) || (edge_cnt_q == MaxEdge);
        sample_s = (edge_cnt_q == half_s);
        vote_s   = majority3(s0_q, s1_q, rx_s);
    end

    // Next-state, datapath and output decision.
    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = wrap_s ? '0 : edge_cnt_q + PrescaleW'(1);
        bit_cnt_d      = wrap_s ? bit_cnt_q + BitW'(1) : bit_cnt_q;
        s0_d           = (edge_cnt_q == half_s - PrescaleW'(2)) ? rx_s : s0_q;
        s1_d           = (edge_cnt_q == half_s - PrescaleW'(1)) ? rx_s : s1_q;
        shift_d        = shift_q;
        pres_d         = pres_q;
        par_en_d       = par_en_q;
        par_typ_d      = par_typ_q;
        par_err_d      = par_err_q;
        stop_err_d     = stop_err_q;
        stop_bad_s     = stop_err_q;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;
        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rx_s) begin
                    state_d    = START;
                    pres_d     = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_err_d  = 1'b0;
                    stop_err_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (sample_s && vote_s) begin
                    state_d = IDLE;
                end else if (wrap_s) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (sample_s) begin
                    shift_d = {vote_s, shift_q[Width-1:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (wrap_s && (bit_cnt_q == BitW'(Width - 1))) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (sample_s) begin
                    par_err_d = parity_mismatch(shift_q, vote_s, par_typ_q);
                end else begin
                    par_err_d = par_err_q;
                end
                state_d = wrap_s ? STOP : PARITY;
            end
            STOP: begin
                if (sample_s) begin
                    stop_bad_s = ~vote_s;
                end else begin
                    stop_bad_s = stop_err_q;
                end
                stop_err_d = stop_bad_s;
                if (wrap_s) begin
                    data_valid_d   = ~(stop_bad_s | par_err_q);
                    parity_error_d = par_err_q;
                    stop_error_d   = stop_bad_s;
                    if (!(stop_bad_s | par_err_q)) begin
                        p_data_d = shift_q;
                    end else begin
                        p_data_d = p_data_q;
                    end
                    // A start bit already on the line is taken here so back-to-back frames keep their pace.
                    if (!rx_s) begin
                        state_d    = START;
                        bit_cnt_d  = '0;
                        pres_d     = Prescale;
                        par_en_d   = PAR_EN;
                        par_typ_d  = PAR_TYP;
                        par_err_d  = 1'b0;
                        stop_err_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, synchronizer and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            s0_q           <= 1'b1;
            s1_q           <= 1'b1;
            shift_q        <= '0;
            pres_q         <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            par_err_q      <= 1'b0;
            stop_err_q     <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= RX_IN;
            sync2_q        <= sync1_q;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            s0_q           <= s0_d;
            s1_q           <= s1_d;
            shift_q        <= shift_d;
            pres_q         <= pres_d;
            par_en_q       <= par_en_d;
            par_typ_q      <= par_typ_d;
            par_err_q      <= par_err_d;
            stop_err_q     <= stop_err_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed frame table, corner
// sequences and randomized frames checked against a frame-level reference model.
module tb_uart_rx_deserializer;
    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Parity_Error;
    logic       Stop_Error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pd;
    } exp_t;

    typedef struct {
        int         p;
        bit         pe;
        bit         typ;
        logic [7:0] d;
        bit         pbit;
        bit         sbit;
        logic       dv;
        logic       per;
        logic       ser;
        logic [7:0] pd;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[6];
    logic [7:0] model_pd;

    uart_rx_deserializer #(.Width(8), .PrescaleW(6)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .Parity_Error(Parity_Error),
        .Stop_Error  (Stop_Error)
    );

    always #5 CLK = ~CLK;

    // Rising-edge counter: after edge k it reads k.
    initial begin
        forever begin
            @(posedge CLK);
            cyc = cyc + 1;
        end
    end

    // Strobe monitor: every strobe must match the oldest pending expectation exactly.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_strobe: no strobe by cycle %0d, required one at cycle %0d",
                         cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (Data_Valid || Parity_Error || Stop_Error) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: cyc=%0d dv=%b pe=%b se=%b, required no strobe",
                             cyc, Data_Valid, Parity_Error, Stop_Error);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || Data_Valid !== e.dv || Parity_Error !== e.pe ||
                        Stop_Error !== e.se || P_DATA !== e.pd) begin
                        n_fail++;
                        $display("FAIL strobe_check: got cyc=%0d dv=%b pe=%b se=%b pdata=%h, required cyc=%0d dv=%b pe=%b se=%b pdata=%h",
                                 cyc, Data_Valid, Parity_Error, Stop_Error, P_DATA,
                                 e.cyc, e.dv, e.pe, e.se, e.pd);
                    end
                end
            end
        end
    end

    function automatic exp_t ref_model(input logic [7:0] d, input int p, input bit pe,
                                       input bit typ, input bit pbit, input bit sbit,
                                       input int e0, input logic [7:0] held);
        exp_t r;
        int   ones;
        bit   par_ok;
        ones   = $countones(d) + (pe ? int'(pbit) : 0);
        par_ok = !pe || ((ones % 2) == (typ ? 1 : 0));
        r.cyc  = e0 + 2 + (10 + (pe ? 1 : 0)) * p;
        r.dv   = par_ok && sbit;
        r.pe   = !par_ok;
        r.se   = !sbit;
        r.pd   = r.dv ? d : held;
        return r;
    endfunction

    // Drives one frame starting just after a rising edge; e0 is the edge that captures the start bit.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit typ,
                              input bit pbit, input bit sbit, input bit scramble,
                              output int e0);
        Prescale = 6'(p);
        PAR_EN   = pe;
        PAR_TYP  = typ;
        RX_IN    = 1'b0;
        e0       = cyc + 1;
        repeat (p) @(posedge CLK);
        #1;
        if (scramble) begin
            Prescale = 6'($urandom_range(63, 0));
            PAR_EN   = 1'($urandom);
            PAR_TYP  = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (p) @(posedge CLK);
            #1;
        end
        if (pe) begin
            RX_IN = pbit;
            repeat (p) @(posedge CLK);
            #1;
        end
        RX_IN = sbit;
        repeat (p) @(posedge CLK);
        #1;
        RX_IN = 1'b1;
    endtask

    task automatic check_quiet(input string name);
        n_checks++;
        if ({P_DATA, Data_Valid, Parity_Error, Stop_Error} !== 11'h000) begin
            n_fail++;
            $display("FAIL %s: got pdata=%h dv=%b pe=%b se=%b, required all zero",
                     name, P_DATA, Data_Valid, Parity_Error, Stop_Error);
        end
    endtask

    initial begin
        exp_t       e;
        int         e0;
        int         p;
        bit         pe, typ, pbit, sbit, cp;
        logic [7:0] d;

        vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[2] = '{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};
        vecs[3] = '{32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[4] = '{16, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07};
        vecs[5] = '{8,  1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07};

        RST      = 1'b0;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        model_pd = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check_quiet("reset_state");
        RST = 1'b1;
        repeat (5) @(posedge CLK);
        #1;

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].d, vecs[i].p, vecs[i].pe, vecs[i].typ, vecs[i].pbit,
                       vecs[i].sbit, 1'b0, e0);
            e.cyc = e0 + 2 + (10 + (vecs[i].pe ? 1 : 0)) * vecs[i].p;
            e.dv  = vecs[i].dv;
            e.pe  = vecs[i].per;
            e.se  = vecs[i].ser;
            e.pd  = vecs[i].pd;
            exp_q.push_back(e);
            model_pd = vecs[i].pd;
            repeat (3 * vecs[i].p) @(posedge CLK);
            #1;
        end

        // Short start glitch, then a good frame.
        Prescale = 6'd16;
        RX_IN    = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        repeat (40) @(posedge CLK);
        #1;
        send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e0);
        e = ref_model(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, e0, model_pd);
        exp_q.push_back(e);
        model_pd = e.pd;
        repeat (40) @(posedge CLK);
        #1;

        // Back-to-back frames with no idle between them.
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e0);
        e = ref_model(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, e0, model_pd);
        exp_q.push_back(e);
        model_pd = e.pd;
        send_frame(8'hFE, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e0);
        e = ref_model(8'hFE, 8, 1'b0, 1'b0, 1'b0, 1'b1, e0, model_pd);
        exp_q.push_back(e);
        model_pd = e.pd;
        repeat (30) @(posedge CLK);
        #1;

        // Reset in the middle of the data bits of a 0x77 frame.
        d        = 8'h77;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            RX_IN = d[i];
            repeat (8) @(posedge CLK);
            #1;
        end
        RST = 1'b0;
        #1;
        check_quiet("reset_midframe_immediate");
        RX_IN = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        check_quiet("reset_midframe_held");
        RST      = 1'b1;
        model_pd = 8'h00;
        repeat (20) @(posedge CLK);
        #1;
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e0);
        e = ref_model(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, e0, model_pd);
        exp_q.push_back(e);
        model_pd = e.pd;
        repeat (30) @(posedge CLK);
        #1;

        // Randomized frames with mid-frame configuration churn.
        for (int n = 0; n < 30; n++) begin
            p    = 8 << $urandom_range(2, 0);
            pe   = 1'($urandom);
            typ  = 1'($urandom);
            d    = 8'($urandom);
            cp   = typ ? ~(^d) : (^d);
            pbit = ($urandom_range(4, 0) == 0) ? ~cp : cp;
            sbit = ($urandom_range(5, 0) != 0);
            send_frame(d, p, pe, typ, pbit, sbit, 1'b1, e0);
            e = ref_model(d, p, pe, typ, pbit, sbit, e0, model_pd);
            exp_q.push_back(e);
            model_pd = e.pd;
            if ($urandom_range(2, 0) != 0) begin
                repeat ($urandom_range(20, 1)) @(posedge CLK);
                #1;
            end
        end

        repeat (400) @(posedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_strobes: got %0d outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
